// File: rtl/axi4_lite_mem_responder_if.sv
// AXI4-Lite bus bundle for the memory responder, including FSM state taps
// so checkers can follow the write and read channels.
interface axi4_lite_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Every channel transfers on a rising edge where valid and ready are both
  // high. Once valid is raised its payload holds until that edge; ready may
  // depend on state only, never on valid.
  logic [ADDR_WIDTH-1:0]   awaddr_i;
  logic                    awvalid_i;
  logic                    awready_o;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic [DATA_WIDTH/8-1:0] wstrb_i;
  logic                    wvalid_i;
  logic                    wready_o;
  logic [1:0]              bresp_o;
  logic                    bvalid_o;
  logic                    bready_i;
  logic [ADDR_WIDTH-1:0]   araddr_i;
  logic                    arvalid_i;
  logic                    arready_o;
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic [1:0]              rresp_o;
  logic                    rvalid_o;
  logic                    rready_i;
  logic [1:0]              w_state_dbg_o;
  logic                    r_state_dbg_o;

  modport slave (
    input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           araddr_i, arvalid_i, rready_i,
    output awready_o, wready_o, bresp_o, bvalid_o, arready_o, rdata_o,
           rresp_o, rvalid_o, w_state_dbg_o, r_state_dbg_o
  );

  modport master (
    output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           araddr_i, arvalid_i, rready_i,
    input  awready_o, wready_o, bresp_o, bvalid_o, arready_o, rdata_o,
           rresp_o, rvalid_o, w_state_dbg_o, r_state_dbg_o
  );
endinterface

// File: rtl/axi4_lite_mem_responder.sv
// AXI4-Lite single-beat responder over a word-addressed flop memory, with a
// read-beat counter that pulses burst_done_o on every BURST_LEN-th beat.
module axi4_lite_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int BURST_LEN  = 16
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic                        clear_i,
  axi4_lite_mem_responder_if.slave    bus,
  output logic                        burst_done_o
);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(MEM_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[2 +: IDX_W];
  endfunction

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  burst_done_q, burst_done_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  logic                  awready, wready, bvalid, arready, rvalid;
  logic                  aw_hs, w_hs, ar_hs, r_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [STRB_W-1:0]     commit_strb;

  assign aw_hs = bus.awvalid_i & awready;
  assign w_hs  = bus.wvalid_i & wready;
  assign ar_hs = bus.arvalid_i & arready;
  assign r_hs  = rvalid & bus.rready_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      beat_q       <= '0;
      burst_done_q <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bresp_q      <= bresp_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      beat_q       <= beat_d;
      burst_done_q <= burst_done_d;
      mem_q        <= mem_d;
    end
  end

  // Write channel: the commit operands come from whichever half of the
  // AW/W pair arrives on the completing edge, the other half from the latch.
  always_comb begin
    w_state_d   = w_state_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bresp_d     = bresp_q;
    commit      = 1'b0;
    commit_addr = awaddr_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;
    if (aw_hs) awaddr_d = bus.awaddr_i;
    if (w_hs) begin
      wdata_d = bus.wdata_i;
      wstrb_d = bus.wstrb_i;
    end
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_d   = W_RESP;
          commit      = 1'b1;
          commit_addr = bus.awaddr_i;
          commit_data = bus.wdata_i;
          commit_strb = bus.wstrb_i;
        end else if (aw_hs) begin
          w_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          w_state_d   = W_RESP;
          commit      = 1'b1;
          commit_data = bus.wdata_i;
          commit_strb = bus.wstrb_i;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          w_state_d   = W_RESP;
          commit      = 1'b1;
          commit_addr = bus.awaddr_i;
        end
      end
      W_RESP: begin
        if (bus.bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (commit) bresp_d = in_range(commit_addr) ? RESP_OKAY : RESP_SLVERR;
  end

  always_comb begin
    mem_d = mem_q;
    if (commit && in_range(commit_addr)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (commit_strb[b]) mem_d[word_idx(commit_addr)][8*b +: 8] = commit_data[8*b +: 8];
      end
    end
  end

  // Read data is taken from mem_q, so a same-edge write to the same word
  // is not visible to this read.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          if (in_range(bus.araddr_i)) begin
            rdata_d = mem_q[word_idx(bus.araddr_i)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_DATA: begin
        if (bus.rready_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    beat_d       = beat_q;
    burst_done_d = 1'b0;
    if (clear_i) begin
      beat_d = '0;
    end else if (r_hs) begin
      beat_d       = beat_q + 1'b1;
      burst_done_d = (beat_q == BEAT_LAST);
    end
  end

  always_comb begin
    awready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_W);
    wready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_AW);
    bvalid  = (w_state_q == W_RESP);
    arready = (r_state_q == R_IDLE);
    rvalid  = (r_state_q == R_DATA);
  end

  assign bus.awready_o     = awready;
  assign bus.wready_o      = wready;
  assign bus.bvalid_o      = bvalid;
  assign bus.bresp_o       = bresp_q;
  assign bus.arready_o     = arready;
  assign bus.rvalid_o      = rvalid;
  assign bus.rdata_o       = rdata_q;
  assign bus.rresp_o       = rresp_q;
  assign bus.w_state_dbg_o = w_state_q;
  assign bus.r_state_dbg_o = r_state_q;
  assign burst_done_o      = burst_done_q;
endmodule

// File: tb/tb_axi4_lite_mem_responder.sv
// Bench for axi4_lite_mem_responder: write/readback vector table, B/R
// scoreboards, and hand sequences for stalls, collisions, bursts and reset.
module tb_axi4_lite_mem_responder;
  localparam int BURST_LEN = 16;

  logic clk;
  logic arst_i;
  logic clear_i;
  logic burst_done_o;

  axi4_lite_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk_i        (clk),
    .arst_i       (arst_i),
    .clear_i      (clear_i),
    .bus          (bus),
    .burst_done_o (burst_done_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  int resp_count  = 0;
  int done_pulses = 0;
  int mdl_beat    = 0;
  logic exp_done  = 1'b0;

  always @(negedge clk) begin
    if (arst_i) begin
      mdl_beat = 0;
      exp_done = 1'b0;
    end else begin
      check("burst_done", burst_done_o, exp_done);
      if (burst_done_o) done_pulses++;
      if (bus.bvalid_o && bus.bready_i) begin
        resp_count++;
        if (exp_b_q.size() == 0) check("unexpected_b", 1, 0);
        else check("bresp", bus.bresp_o, exp_b_q.pop_front());
      end
      if (bus.rvalid_o && bus.rready_i) begin
        resp_count++;
        if (exp_r_q.size() == 0) check("unexpected_r", 1, 0);
        else check("rresp_rdata", {bus.rresp_o, bus.rdata_o}, exp_r_q.pop_front());
      end
      if (clear_i) begin
        mdl_beat = 0;
        exp_done = 1'b0;
      end else if (bus.rvalid_o && bus.rready_i) begin
        exp_done = (mdl_beat == BURST_LEN - 1);
        mdl_beat = (mdl_beat + 1) % BURST_LEN;
      end else begin
        exp_done = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic issue_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] eb);
    int n;
    bit aw_ok, w_ok;
    n = 0; aw_ok = 0; w_ok = 0;
    exp_b_q.push_back(eb);
    bus.awaddr_i = a; bus.awvalid_i = 1'b1;
    bus.wdata_i = d; bus.wstrb_i = s; bus.wvalid_i = 1'b1;
    while (!(aw_ok && w_ok) && n < 20) begin
      @(negedge clk);
      if (bus.awvalid_i && bus.awready_o) aw_ok = 1;
      if (bus.wvalid_i && bus.wready_o) w_ok = 1;
      @(posedge clk); #1;
      if (aw_ok) bus.awvalid_i = 1'b0;
      if (w_ok) bus.wvalid_i = 1'b0;
      n++;
    end
    bus.awvalid_i = 1'b0;
    bus.wvalid_i  = 1'b0;
    check("aw_w_handshake", {aw_ok, w_ok}, 2'b11);
  endtask

  task automatic issue_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    int n;
    bit ok;
    n = 0; ok = 0;
    exp_r_q.push_back({r, d});
    bus.araddr_i = a; bus.arvalid_i = 1'b1;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = bus.arvalid_i && bus.arready_o;
      @(posedge clk); #1;
      n++;
    end
    bus.arvalid_i = 1'b0;
    check("ar_handshake", ok, 1);
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    while (exp_b_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    check("b_drain", exp_b_q.size(), 0);
  endtask

  task automatic wait_r();
    int n;
    n = 0;
    while (exp_r_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    check("r_drain", exp_r_q.size(), 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] eb);
    issue_write(a, d, s, eb);
    wait_b();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    issue_read(a, d, r);
    wait_r();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t vecs[9];
  int   base;

  initial begin
    vecs[0] = '{32'h0000_0013, 32'h1234_5678, 4'b1000, 2'b00, 32'h12AD_CAFE, 2'b00};
    vecs[1] = '{32'h0000_0000, 32'hA5A5_A5A5, 4'b1111, 2'b00, 32'hA5A5_A5A5, 2'b00};
    vecs[2] = '{32'h0000_00FC, 32'h1122_3344, 4'b1111, 2'b00, 32'h1122_3344, 2'b00};
    vecs[3] = '{32'h0000_0100, 32'hFFFF_FFFF, 4'b1111, 2'b10, 32'h0000_0000, 2'b10};
    vecs[4] = '{32'h8000_0010, 32'hFFFF_FFFF, 4'b1111, 2'b10, 32'h0000_0000, 2'b10};
    vecs[5] = '{32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 2'b00, 32'h12AD_CAFE, 2'b00};
    vecs[6] = '{32'h0000_0000, 32'hFFFF_FFFF, 4'b0000, 2'b00, 32'hA5A5_A5A5, 2'b00};
    vecs[7] = '{32'h0000_0020, 32'h00FF_00FF, 4'b0101, 2'b00, 32'h00FF_00FF, 2'b00};
    vecs[8] = '{32'h0000_0021, 32'hAABB_CCDD, 4'b0010, 2'b00, 32'h00FF_CCFF, 2'b00};

    arst_i = 1'b1; clear_i = 1'b0;
    bus.awaddr_i = '0; bus.awvalid_i = 1'b0;
    bus.wdata_i = '0; bus.wstrb_i = '0; bus.wvalid_i = 1'b0;
    bus.bready_i = 1'b1;
    bus.araddr_i = '0; bus.arvalid_i = 1'b0;
    bus.rready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 arst_i = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_outputs", {bus.bvalid_o, bus.rvalid_o, bus.bresp_o, bus.rresp_o, burst_done_o}, 7'b0);
    check("rst_rdata", bus.rdata_o, 32'h0);
    check("rst_readies", {bus.awready_o, bus.wready_o, bus.arready_o}, 3'b111);
    check("rst_states", {bus.w_state_dbg_o, bus.r_state_dbg_o}, 3'b000);
    @(posedge clk); #1;

    // AW+W together, one-cycle B latency, then one-cycle R latency
    exp_b_q.push_back(2'b00);
    bus.awaddr_i = 32'h10; bus.awvalid_i = 1'b1;
    bus.wdata_i = 32'hDEAD_BEEF; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
    @(negedge clk);
    check("wr_pre_bvalid", bus.bvalid_o, 1'b0);
    @(posedge clk); #1;
    bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
    @(negedge clk);
    check("wr_bvalid_latency", bus.bvalid_o, 1'b1);
    wait_b();
    exp_r_q.push_back({2'b00, 32'hDEAD_BEEF});
    bus.araddr_i = 32'h10; bus.arvalid_i = 1'b1;
    @(negedge clk);
    check("rd_pre_rvalid", bus.rvalid_o, 1'b0);
    @(posedge clk); #1;
    bus.arvalid_i = 1'b0;
    @(negedge clk);
    check("rd_rvalid_latency", bus.rvalid_o, 1'b1);
    wait_r();

    // W two cycles ahead of AW
    bus.wdata_i = 32'h0000_CAFE; bus.wstrb_i = 4'b0011; bus.wvalid_i = 1'b1;
    @(posedge clk); #1;
    bus.wvalid_i = 1'b0;
    @(negedge clk);
    check("have_w_state", bus.w_state_dbg_o, 2'd2);
    check("have_w_readies", {bus.awready_o, bus.wready_o}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    check("have_w_hold", {bus.w_state_dbg_o, bus.bvalid_o}, 3'b100);
    @(posedge clk); #1;
    exp_b_q.push_back(2'b00);
    bus.awaddr_i = 32'h10; bus.awvalid_i = 1'b1;
    @(posedge clk); #1;
    bus.awvalid_i = 1'b0;
    wait_b();
    do_read(32'h10, 32'hDEAD_CAFE, 2'b00);

    // vector table
    for (int i = 0; i < 9; i++) begin
      do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_bresp);
      do_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_rresp);
    end

    // write commit and AR to the same word on one edge
    exp_b_q.push_back(2'b00);
    exp_r_q.push_back({2'b00, 32'h00FF_CCFF});
    bus.awaddr_i = 32'h20; bus.awvalid_i = 1'b1;
    bus.wdata_i = 32'h7777_7777; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
    bus.araddr_i = 32'h20; bus.arvalid_i = 1'b1;
    @(negedge clk);
    check("collide_readies", {bus.awready_o, bus.wready_o, bus.arready_o}, 3'b111);
    @(posedge clk); #1;
    bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0; bus.arvalid_i = 1'b0;
    wait_b();
    wait_r();
    do_read(32'h20, 32'h7777_7777, 2'b00);

    // responses held under back-pressure
    bus.bready_i = 1'b0; bus.rready_i = 1'b0;
    issue_write(32'h04, 32'h0BAD_F00D, 4'hF, 2'b00);
    issue_read(32'hFC, 32'h1122_3344, 2'b00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valids", {bus.bvalid_o, bus.rvalid_o, bus.bresp_o, bus.rresp_o}, 6'b110000);
      check("stall_rdata", bus.rdata_o, 32'h1122_3344);
      check("stall_readies", {bus.awready_o, bus.wready_o, bus.arready_o}, 3'b000);
      @(posedge clk); #1;
    end
    bus.bready_i = 1'b1; bus.rready_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_release_idle", {bus.w_state_dbg_o, bus.r_state_dbg_o, bus.bvalid_o, bus.rvalid_o}, 5'b0);
    check("stall_drained", exp_b_q.size() + exp_r_q.size(), 0);
    @(posedge clk); #1;
    do_read(32'h04, 32'h0BAD_F00D, 2'b00);

    // burst accounting with clear, OKAY and SLVERR beats mixed
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    base = done_pulses;
    for (int i = 0; i < BURST_LEN; i++) begin
      if (i % 2 == 0) do_read(32'h00, 32'hA5A5_A5A5, 2'b00);
      else do_read(32'h100, 32'h0, 2'b10);
      if (i == BURST_LEN - 2) begin
        @(posedge clk); #1;
        check("burst_no_done_15", done_pulses, base);
      end
    end
    @(posedge clk); #1;
    check("burst_done_16", done_pulses, base + 1);
    for (int i = 0; i < 5; i++) do_read(32'h00, 32'hA5A5_A5A5, 2'b00);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    base = done_pulses;
    for (int i = 0; i < BURST_LEN - 1; i++) do_read(32'hFC, 32'h1122_3344, 2'b00);
    @(posedge clk); #1;
    check("clear_no_done_15", done_pulses, base);
    do_read(32'hFC, 32'h1122_3344, 2'b00);
    @(posedge clk); #1;
    check("clear_done_16", done_pulses, base + 1);

    // reset in W_HAVE_AW and R_DATA
    bus.rready_i = 1'b0;
    bus.awaddr_i = 32'h08; bus.awvalid_i = 1'b1;
    @(posedge clk); #1;
    bus.awvalid_i = 1'b0;
    issue_read(32'h00, 32'hA5A5_A5A5, 2'b00);
    @(negedge clk);
    check("pre_rst_states", {bus.w_state_dbg_o, bus.r_state_dbg_o}, 3'b011);
    @(posedge clk); #1;
    arst_i = 1'b1;
    #1;
    check("arst_outputs", {bus.bvalid_o, bus.rvalid_o, bus.bresp_o, bus.rresp_o, burst_done_o}, 7'b0);
    check("arst_rdata", bus.rdata_o, 32'h0);
    check("arst_states", {bus.w_state_dbg_o, bus.r_state_dbg_o}, 3'b000);
    exp_b_q.delete();
    exp_r_q.delete();
    @(posedge clk); #1;
    arst_i = 1'b0;
    bus.rready_i = 1'b1; bus.bready_i = 1'b1;
    base = resp_count;
    repeat (6) @(posedge clk);
    #1;
    check("no_resp_after_reset", resp_count, base);
    do_read(32'h00, 32'h0, 2'b00);
    do_read(32'hFC, 32'h0, 2'b00);
    do_read(32'h10, 32'h0, 2'b00);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
